// File: rtl/mem_stream_reader.sv
// mem_stream_reader: turns a stream of SRAM addresses into a stream of read
// words. One synchronous read per accepted address; returned words land in a
// small in-order FIFO. Credit accounting on the address side guarantees every
// issued read has a FIFO slot waiting for it.
//
// state | meaning
// IDLE  | waiting for start, addresses ignored
// RUN   | accepting addresses until the one marked last is taken
// DRAIN | no new addresses, emptying FIFO until the last word is popped
module mem_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  addr_valid,
  output logic                  addr_ready,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  addr_last,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            inflight;
  logic            inflight_last;
  logic [DATA_WIDTH:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0] head;
  logic            push;
  logic            pop;
  logic [SW-1:0]   occupancy;
  logic [SW-1:0]   limit;

  // Every read issued last cycle becomes a push this cycle.
  assign push      = inflight;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign head      = fifo_mem[rd_ptr];

  // Mask the head so stale array contents never leak out while empty.
  assign out_data = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_last = out_valid & head[DATA_WIDTH];

  // Credit check written as count + inflight < depth + pop to avoid an
  // underflowing subtraction; a pop this cycle frees a slot for this read.
  assign occupancy  = SW'(count) + SW'(inflight);
  assign limit      = SW'(FIFO_DEPTH) + SW'(pop);
  assign addr_ready = (state == RUN) && (occupancy < limit);
  assign mem_en     = addr_valid & addr_ready;
  assign mem_addr   = addr_in;

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) & pop & out_last;

  // Stream sequencing: start opens a stream, last address closes intake,
  // popping the last word returns to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (mem_en && addr_last) state <= DRAIN;
        DRAIN:   if (pop && out_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read-in-flight tracking, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      inflight      <= mem_en;
      inflight_last <= mem_en & addr_last;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the head is masked by count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {inflight_last, mem_rdata};
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: directed streams with a scoreboard queue of
// expected {last, data} words filled at each address handshake and drained
// by an independent monitor on the output side.
module tb_mem_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       addr_valid = 1'b0;
  logic       addr_ready;
  logic [3:0] addr_in = '0;
  logic       addr_last = 1'b0;
  logic       mem_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];
  int hs_cyc[$];
  int pop_cyc[$];
  logic [8:0] e;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_word = '0;

  mem_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_in(addr_in),
    .addr_last(addr_last), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM: word at address a is {a, a} (= a * 0x11).
  always @(posedge clk) if (mem_en) mem_rdata <= {mem_addr, mem_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard compare on every pop, done only with last pop,
  // head held stable under backpressure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %0h with empty scoreboard", {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[7:0]));
          chk("out_last", 32'(out_last), 32'(e[8]));
          chk("done_on_pop", 32'(done), 32'(e[8]));
        end
        pop_cyc.push_back(cyc);
        pops++;
      end else begin
        chk("done_without_pop", 32'(done), 32'd0);
      end
      if (done) done_cnt++;
      if (prev_hold && out_valid) chk("head_stable", 32'({out_last, out_data}), 32'(prev_word));
      prev_hold = out_valid && !out_ready;
      prev_word = {out_last, out_data};
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Present one address and hold it until handshake; addr_valid stays high
  // afterwards so consecutive calls give back-to-back traffic.
  task automatic send(input logic [3:0] a, input logic last);
    bit ok = 0;
    addr_valid = 1'b1;
    addr_in = a;
    addr_last = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (addr_ready) begin
        chk("mem_en", 32'(mem_en), 32'd1);
        chk("mem_addr", 32'(mem_addr), 32'(a));
        exp_q.push_back({last, a, a});
        hs_cyc.push_back(cyc);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: addr %0h got no addr_ready, required 1", a);
    end
  endtask

  task automatic wait_done(input int base);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      if (done_cnt > base) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done_cnt %0d required > %0d", done_cnt, base);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr_ready"}, 32'(addr_ready), 32'd0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_done;
    int base_pops;
    int hs0;

    // 1. Reset with random inputs, then idle until start.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom); addr_valid = 1'($urandom); addr_in = 4'($urandom);
      addr_last = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      check_reset_outputs("reset");
    end
    @(posedge clk); #1;
    start = 1'b0; addr_valid = 1'b1; addr_in = 4'h2; addr_last = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_addr_ready", 32'(addr_ready), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1 addr_valid = 1'b0;

    // 2. Basic stream 3,4,5,6 with out_ready high.
    out_ready = 1'b1;
    hs_cyc.delete(); pop_cyc.delete();
    base_done = done_cnt;
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send(4'h3, 1'b0); send(4'h4, 1'b0); send(4'h5, 1'b0); send(4'h6, 1'b1);
    addr_valid = 1'b0; addr_last = 1'b0;
    wait_done(base_done);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("basic_done_count", 32'(done_cnt - base_done), 32'd1);
    if (hs_cyc.size() == 4 && pop_cyc.size() == 4) begin
      hs0 = hs_cyc[0];
      chk("basic_latency", 32'(pop_cyc[0] - hs0), 32'd2);
      for (int i = 1; i < 4; i++) begin
        chk("basic_hs_rate", 32'(hs_cyc[i] - hs0), 32'(i));
        chk("basic_pop_rate", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
      end
    end else begin
      checks++;
      errors++;
      $display("FAIL basic_counts: hs %0d pops %0d required 4 and 4", hs_cyc.size(), pop_cyc.size());
    end

    // 3. Backpressure: 6 addresses, out_ready low for 10 cycles.
    out_ready = 1'b0;
    hs_cyc.delete();
    base_done = done_cnt;
    base_pops = pops;
    pulse_start();
    fork
      begin
        send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h7, 1'b0);
        send(4'h8, 1'b0); send(4'h9, 1'b0); send(4'hA, 1'b1);
        addr_valid = 1'b0; addr_last = 1'b0;
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", 32'(hs_cyc.size()), 32'd4);
        chk("bp_addr_ready", 32'(addr_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_done(base_done);
    @(negedge clk);
    chk("bp_pops", 32'(pops - base_pops), 32'd6);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4. Single-address stream at 0xF.
    base_done = done_cnt;
    base_pops = pops;
    pulse_start();
    send(4'hF, 1'b1);
    addr_valid = 1'b0; addr_last = 1'b0;
    wait_done(base_done);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("single_pops", 32'(pops - base_pops), 32'd1);
    chk("single_done_count", 32'(done_cnt - base_done), 32'd1);

    // 5. start pulses during RUN and DRAIN are ignored.
    base_done = done_cnt;
    base_pops = pops;
    out_ready = 1'b0;
    pulse_start();
    send(4'hB, 1'b0);
    addr_valid = 1'b0;
    pulse_start();
    send(4'hC, 1'b1);
    addr_valid = 1'b0; addr_last = 1'b0;
    pulse_start();
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(base_done);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy_start_done_count", 32'(done_cnt - base_done), 32'd1);
    chk("busy_start_pops", 32'(pops - base_pops), 32'd2);
    chk("busy_start_idle", 32'(busy), 32'd0);

    // 6. Reset with 2 words buffered and 1 read in flight.
    out_ready = 1'b0;
    pulse_start();
    send(4'h7, 1'b0); send(4'h8, 1'b0); send(4'h9, 1'b0);
    addr_valid = 1'b0;
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_out_data", 32'(out_data), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_out_valid", 32'(out_valid), 32'd0);
      chk("post_reset_busy", 32'(busy), 32'd0);
    end
    base_done = done_cnt;
    base_pops = pops;
    pulse_start();
    send(4'h5, 1'b0); send(4'hE, 1'b1);
    addr_valid = 1'b0; addr_last = 1'b0;
    wait_done(base_done);
    @(negedge clk);
    chk("post_reset_pops", 32'(pops - base_pops), 32'd2);
    chk("post_reset_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Downstream consumer of the address-increment stage in the tensor-core load path. It accepts a stream of SRAM addresses over a valid/ready handshake, issues one synchronous SRAM read per accepted address, and buffers the returned words in a small output FIFO that the operand register file drains. Credit-based flow control ensures no read is issued without a guaranteed FIFO slot, so no returned data is lost under backpressure.

## Interface

- ADDR_WIDTH, 4, width of SRAM address
- DATA_WIDTH, 8, width of SRAM read word
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; begins a stream when idle
- addr_valid  input  1  address available
- addr_ready  output  1  address accepted this cycle when high together with addr_valid
- addr_in  input  ADDR_WIDTH  address to read
- addr_last  input  1  qualifies addr_in as final address of the stream
- mem_en  output  1  SRAM read enable
- mem_addr  output  ADDR_WIDTH  SRAM read address
- mem_rdata  input  DATA_WIDTH  SRAM read data, valid exactly one cycle after mem_en
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head
- out_data  output  DATA_WIDTH  FIFO head word
- out_last  output  1  head word belongs to the addr_last address
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse when the last word is popped

## Operation

- FSM states: IDLE, RUN, DRAIN.
- IDLE: addr_ready=0. start=1 → RUN. Addresses presented in IDLE are ignored.
- RUN: address handshake (addr_valid & addr_ready) with addr_last=1 → DRAIN.
- DRAIN: addr_ready=0. Pop of the word with out_last=1 → IDLE, and done=1 in that same cycle.
- start is ignored outside IDLE.
- Credit rule: addr_ready = (state==RUN) & (count + inflight − pop < FIFO_DEPTH).
  - count is FIFO occupancy.
  - inflight is 1 if a read was issued in the previous cycle.
  - pop = out_valid & out_ready.
  - This creates a combinational path from out_ready to addr_ready; that path is permitted.
- mem_en = addr_valid & addr_ready (combinational).
- mem_addr = addr_in (pass-through).
- A one-bit registered inflight flag carries addr_last alongside each read.
- The cycle after mem_en, mem_rdata and the carried last bit are written into the FIFO tail.
- FIFO ordering and entries:
  - Strict in-order.
  - Each entry is {last, data}.
  - Registered head: out_valid = (count != 0).
- Simultaneous push and pop are both performed; count is unchanged.
- Because of the credit rule, a push never occurs when the FIFO is full, and a pop never occurs when it is empty.
- Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.
- Reset (asynchronous, any time, including mid-stream):
  - State returns to IDLE.
  - count, pointers and inflight are cleared.
  - All in-flight and buffered data are discarded.
  - Output reset values: addr_ready=0, mem_en=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - mem_addr follows addr_in, and is don't-care while mem_en=0.

## Timing

- Address handshake in cycle N:
  - mem_en=1 in cycle N.
  - SRAM data arrives in cycle N+1.
  - out_valid=1 at N+2 at the earliest.
  - Latency is 2 cycles.
- With out_ready held high and FIFO_DEPTH ≥ 2, the block sustains one address per cycle.
- done is asserted in the same cycle as the final pop and never overlaps a new start.
- The earliest new start is the cycle after done.
- busy rises the cycle after start and falls the cycle after done.
- out_data and out_last are stable while out_valid=1 and out_ready=0.

## Test plan

1. Reset: hold rst_n=0 with random inputs → all outputs at their reset values. Release → still idle until start.
2. Basic stream: start, then addresses 3,4,5,6 back-to-back (6 with last), SRAM model rdata = addr×0x11, out_ready=1 → out_data 0x33, 0x44, 0x55, 0x66 on consecutive cycles starting 2 cycles after the first handshake; out_last only on 0x66; done in the same cycle; busy drops the next cycle.
3. Backpressure: out_ready=0 for 10 cycles during a 6-address stream → exactly 4 addresses accepted, then addr_ready=0. Release out_ready → all 6 words emerge in order, none lost or duplicated.
4. Single-address stream: start, addr 0xF with last → one word with out_last=1; done pulses once; the address counter's wrap is irrelevant to this block.
5. start while busy: pulse start during RUN and again during DRAIN → ignored; the stream completes normally with a single done.
6. Reset mid-stream: assert rst_n=0 while 2 words are buffered and 1 read is in flight → out_valid=0 immediately. After release the FIFO is empty and a new stream starts cleanly from IDLE.
